// File: rtl/pio_mux_gen.sv
// pio_mux_gen: bus-programmable GPIO with a per-pin alternate-function mux,
// synchronised pad inputs and a maskable, sticky edge interrupt.
module pio_mux_gen #(
  parameter int PINS        = 32,
  parameter int MSEL_W      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                iCLK,
  input  logic                                iRESET,
  input  logic [4:0]                          iADDRESS,
  input  logic                                iREAD,
  input  logic                                iWRITE,
  input  logic [31:0]                         iWRITE_DATA,
  output logic [31:0]                         oREAD_DATA,
  output logic                                oREAD_DATAVALID,
  input  logic [PINS-1:0]                     iPIN_IN,
  output logic [PINS-1:0]                     oPIN_OUT,
  output logic [PINS-1:0]                     oPIN_OE,
  input  logic [PINS*((1<<MSEL_W)-1)-1:0]     iALT_OUT,
  input  logic [PINS*((1<<MSEL_W)-1)-1:0]     iALT_OE,
  output logic                                oIRQ
);

  localparam int NF = (1 << MSEL_W) - 1;
  localparam int MB = PINS * MSEL_W;
  localparam int NW = (MB + 31) / 32;
  localparam int PW = $clog2(SYNC_STAGES + 2);

  logic [PINS-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d;
  logic [PINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [PINS-1:0] status_q, status_d, w1c, edge_set, wdata;
  logic [NW*32-1:0] msel_q, msel_d;
  logic [SYNC_STAGES-1:0][PINS-1:0] sync_q;
  logic [PINS-1:0] prev_q, sync_last, rise, fall;
  logic [PW-1:0]   prime_q;
  logic [31:0]     rdata_q, rd_mux;
  logic            rvalid_q, irq_q, edge_en;
  int              msel_w;

  assign wdata     = iWRITE_DATA[PINS-1:0];
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev_q;
  assign fall      = ~sync_last & prev_q;
  // Edges stay masked until the synchroniser has flushed its reset zeros.
  assign edge_en   = (prime_q == '0);

  always_comb msel_w = int'(iADDRESS) - 16;

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    msel_d    = msel_q;
    w1c       = '0;
    if (iWRITE) begin
      case (iADDRESS)
        5'd1:    out_d     = wdata;
        5'd2:    dir_d     = wdata;
        5'd3:    mask_d    = wdata;
        5'd4:    rise_en_d = wdata;
        5'd5:    fall_en_d = wdata;
        5'd6:    w1c       = wdata;
        5'd7:    out_d     = out_q | wdata;
        5'd8:    out_d     = out_q & ~wdata;
        default: ;
      endcase
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < 32; b++)
          if (msel_w == w && (w * 32 + b) < MB) msel_d[w*32+b] = iWRITE_DATA[b];
    end
    edge_set = edge_en ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
    // A new edge beats a simultaneous clear.
    status_d = (status_q & ~w1c) | edge_set;
  end

  always_comb begin
    rd_mux = '0;
    case (iADDRESS)
      5'd0:    rd_mux = 32'(sync_last);
      5'd1:    rd_mux = 32'(out_q);
      5'd2:    rd_mux = 32'(dir_q);
      5'd3:    rd_mux = 32'(mask_q);
      5'd4:    rd_mux = 32'(rise_en_q);
      5'd5:    rd_mux = 32'(fall_en_q);
      5'd6:    rd_mux = 32'(status_q);
      default: begin
        for (int w = 0; w < NW; w++)
          if (msel_w == w) rd_mux = msel_q[w*32 +: 32];
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      out_q     <= '0;
      dir_q     <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      msel_q    <= '0;
      sync_q    <= '0;
      prev_q    <= '0;
      prime_q   <= PW'(SYNC_STAGES + 1);
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      msel_q    <= msel_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], iPIN_IN};
      prev_q    <= sync_last;
      if (prime_q != '0) prime_q <= prime_q - 1'b1;
      if (iREAD) rdata_q <= rd_mux;
      rvalid_q  <= iREAD;
      irq_q     <= |(status_q & mask_q);
    end
  end

  always_comb begin
    oPIN_OUT = '0;
    oPIN_OE  = '0;
    for (int i = 0; i < PINS; i++) begin
      oPIN_OUT[i] = out_q[i];
      oPIN_OE[i]  = dir_q[i];
      for (int f = 1; f <= NF; f++) begin
        if (msel_q[i*MSEL_W +: MSEL_W] == MSEL_W'(f)) begin
          oPIN_OUT[i] = iALT_OUT[(f-1)*PINS+i];
          oPIN_OE[i]  = iALT_OE[(f-1)*PINS+i];
        end
      end
    end
  end

  assign oREAD_DATA      = rdata_q;
  assign oREAD_DATAVALID = rvalid_q;
  assign oIRQ            = irq_q;

endmodule

// File: tb/tb_pio_mux_gen.sv
// Bench for pio_mux_gen: directed bus/pin stimulus, a per-cycle behavioural
// model compare, and literal checks on the key timing points.
module tb_pio_mux_gen;
  localparam int S = 2;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic [4:0]  iADDRESS = '0;
  logic        iREAD = 1'b0, iWRITE = 1'b0;
  logic [31:0] iWRITE_DATA = '0;
  logic [31:0] oREAD_DATA;
  logic        oREAD_DATAVALID, oIRQ;
  logic [31:0] iPIN_IN = '0, oPIN_OUT, oPIN_OE;
  logic [95:0] iALT_OUT = '0, iALT_OE = '0;

  pio_mux_gen #(.PINS(32), .MSEL_W(2), .SYNC_STAGES(S)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iADDRESS(iADDRESS), .iREAD(iREAD),
    .iWRITE(iWRITE), .iWRITE_DATA(iWRITE_DATA), .oREAD_DATA(oREAD_DATA),
    .oREAD_DATAVALID(oREAD_DATAVALID), .iPIN_IN(iPIN_IN), .oPIN_OUT(oPIN_OUT),
    .oPIN_OE(oPIN_OE), .iALT_OUT(iALT_OUT), .iALT_OE(iALT_OE), .oIRQ(oIRQ));

  always #5 iCLK = ~iCLK;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [31:0] m_out, m_dir, m_mask, m_rise, m_fall, m_status, m_rdata;
  logic        m_rvalid, m_irq;
  logic [1:0]  m_sel [32];
  logic [31:0] hist [0:S];
  int          cnt;
  logic [31:0] rd, setb, w1c, rise, fall;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      5'd0: r = hist[S-1];
      5'd1: r = m_out;
      5'd2: r = m_dir;
      5'd3: r = m_mask;
      5'd4: r = m_rise;
      5'd5: r = m_fall;
      5'd6: r = m_status;
      default: for (int i = 0; i < 32; i++)
        if (16 + (i * 2) / 32 == int'(a)) r[(i*2)%32 +: 2] = m_sel[i];
    endcase
    return r;
  endfunction

  always @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      m_out = 0; m_dir = 0; m_mask = 0; m_rise = 0; m_fall = 0; m_status = 0;
      m_rdata = 0; m_rvalid = 0; m_irq = 0; cnt = 0;
      for (int i = 0; i < 32; i++) m_sel[i] = 2'd0;
      for (int k = 0; k <= S; k++) hist[k] = 0;
    end else begin
      rd = m_read(iADDRESS);
      m_irq = |(m_status & m_mask);
      m_rvalid = iREAD;
      if (iREAD) m_rdata = rd;
      cnt++;
      rise = hist[S-1] & ~hist[S];
      fall = ~hist[S-1] & hist[S];
      setb = (cnt >= S + 2) ? ((rise & m_rise) | (fall & m_fall)) : 32'h0;
      w1c = 0;
      if (iWRITE) begin
        case (iADDRESS)
          5'd1: m_out = iWRITE_DATA;
          5'd2: m_dir = iWRITE_DATA;
          5'd3: m_mask = iWRITE_DATA;
          5'd4: m_rise = iWRITE_DATA;
          5'd5: m_fall = iWRITE_DATA;
          5'd6: w1c = iWRITE_DATA;
          5'd7: m_out = m_out | iWRITE_DATA;
          5'd8: m_out = m_out & ~iWRITE_DATA;
          5'd16: for (int i = 0; i < 16; i++) m_sel[i] = iWRITE_DATA[i*2 +: 2];
          5'd17: for (int i = 16; i < 32; i++) m_sel[i] = iWRITE_DATA[(i-16)*2 +: 2];
          default: ;
        endcase
      end
      m_status = (m_status & ~w1c) | setb;
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = iPIN_IN;
    end
  end

  logic [31:0] exp_out, exp_oe;
  always @(negedge iCLK) begin
    if (!iRESET) begin
      for (int i = 0; i < 32; i++) begin
        if (m_sel[i] == 2'd0) begin
          exp_out[i] = m_out[i];
          exp_oe[i]  = m_dir[i];
        end else begin
          exp_out[i] = iALT_OUT[(int'(m_sel[i]) - 1) * 32 + i];
          exp_oe[i]  = iALT_OE[(int'(m_sel[i]) - 1) * 32 + i];
        end
      end
      chk("model_pin_out", oPIN_OUT, exp_out);
      chk("model_pin_oe", oPIN_OE, exp_oe);
      chk("model_irq", 32'(oIRQ), 32'(m_irq));
      chk("model_rvalid", 32'(oREAD_DATAVALID), 32'(m_rvalid));
      if (m_rvalid) chk("model_rdata", oREAD_DATA, m_rdata);
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    iWRITE = 1'b1; iADDRESS = a; iWRITE_DATA = d;
    tick();
    iWRITE = 1'b0;
  endtask

  task automatic bus_read(input string nm, input logic [4:0] a, input logic [31:0] exp);
    iREAD = 1'b1; iADDRESS = a;
    tick();
    iREAD = 1'b0;
    chk({nm, "_valid"}, 32'(oREAD_DATAVALID), 32'd1);
    chk(nm, oREAD_DATA, exp);
  endtask

  initial begin
    repeat (2) tick();
    iRESET = 1'b0;
    tick();
    chk("reset_oe", oPIN_OE, 32'h0);
    bus_read("rd_dir_reset", 5'd2, 32'h0);
    bus_read("rd_msel_reset", 5'd16, 32'h0);

    bus_write(5'd2, 32'h0000_000F);
    bus_write(5'd1, 32'h5);
    chk("out_after_write", oPIN_OUT & 32'hF, 32'h5);
    bus_write(5'd7, 32'h2);
    chk("out_after_set", oPIN_OUT & 32'hF, 32'h7);
    bus_write(5'd8, 32'h1);
    chk("out_after_clr", oPIN_OUT & 32'hF, 32'h6);
    chk("oe_dir", oPIN_OE & 32'hF, 32'hF);
    bus_read("rd_out", 5'd1, 32'h6);
    bus_read("rd_setclr_wo", 5'd7, 32'h0);

    iALT_OUT[66] = 1'b0; iALT_OE[66] = 1'b0;
    bus_write(5'd16, 32'h0000_0030);
    chk("alt_out_low", oPIN_OUT & 32'hF, 32'h2);
    chk("alt_oe_low", oPIN_OE & 32'hF, 32'hB);
    iALT_OUT[66] = 1'b1; iALT_OE[66] = 1'b1;
    tick();
    chk("alt_out_high", oPIN_OUT & 32'hF, 32'h6);
    chk("alt_oe_high", oPIN_OE & 32'hF, 32'hF);
    bus_read("rd_msel", 5'd16, 32'h30);
    bus_write(5'd16, 32'h0);

    bus_write(5'd4, 32'h1);
    bus_write(5'd3, 32'h1);
    iPIN_IN[0] = 1'b1;
    repeat (S + 1) tick();
    chk("irq_not_yet", 32'(oIRQ), 32'd0);
    tick();
    chk("irq_rise", 32'(oIRQ), 32'd1);
    bus_write(5'd6, 32'h1);
    chk("irq_hold_w1c", 32'(oIRQ), 32'd1);
    tick();
    chk("irq_cleared", 32'(oIRQ), 32'd0);
    iPIN_IN[0] = 1'b0;
    repeat (5) tick();
    chk("irq_no_fall", 32'(oIRQ), 32'd0);
    bus_read("rd_status_nofall", 5'd6, 32'h0);
    bus_read("rd_in", 5'd0, 32'h0);

    iPIN_IN = 32'hFFFF_FFFF;
    iRESET = 1'b1;
    repeat (2) tick();
    iRESET = 1'b0;
    bus_write(5'd4, 32'hFFFF_FFFF);
    bus_write(5'd3, 32'hFFFF_FFFF);
    repeat (4) tick();
    bus_read("rd_status_prime", 5'd6, 32'h0);
    chk("irq_prime", 32'(oIRQ), 32'd0);
    bus_read("rd_in_high", 5'd0, 32'hFFFF_FFFF);

    iPIN_IN[0] = 1'b0;
    repeat (5) tick();
    iPIN_IN[0] = 1'b1;
    repeat (S) tick();
    bus_write(5'd6, 32'h1);
    bus_read("rd_status_setwins", 5'd6, 32'h1);
    chk("model_status0", 32'(m_status[0]), 32'd1);
    chk("irq_setwins", 32'(oIRQ), 32'd1);

    bus_write(5'd2, 32'h0000_000F);
    chk("oe_before_reset", oPIN_OE & 32'hF, 32'hF);
    iREAD = 1'b1; iADDRESS = 5'd2;
    #2;
    iRESET = 1'b1;
    #1;
    chk("async_oe", oPIN_OE, 32'h0);
    chk("async_irq", 32'(oIRQ), 32'd0);
    chk("async_rvalid", 32'(oREAD_DATAVALID), 32'd0);
    iREAD = 1'b0;
    tick();
    chk("reset_rvalid", 32'(oREAD_DATAVALID), 32'd0);
    iRESET = 1'b0;
    tick();
    chk("post_reset_rvalid", 32'(oREAD_DATAVALID), 32'd0);
    chk("post_reset_oe", oPIN_OE, 32'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
